// File: rtl/ps2_scancode_decoder_pkg.sv
// ps2_pkg: shared constants for the PS/2 Set-2 scan-code decoder.
//   - prefix / status byte values, arrow-key codes, fake-shift codes
//   - decoder FSM state enum
//   - the 8-byte Pause key sequence
//   - small byte classification helpers
package ps2_pkg;

  localparam logic [7:0] PS2_EXT     = 8'hE0;
  localparam logic [7:0] PS2_BRK     = 8'hF0;
  localparam logic [7:0] PS2_PAUSE   = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
  localparam logic [7:0] PS2_BAT_ERR = 8'hFC;
  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;

  localparam logic [7:0] PS2_ARROW_UP    = 8'h75;
  localparam logic [7:0] PS2_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] PS2_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_ARROW_RIGHT = 8'h74;

  // Shift codes the keyboard injects around extended keys (PrtSc etc.)
  localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } ps2_state_e;

  localparam logic [7:0] PS2_PAUSE_SEQ [8] = '{
    8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77
  };

  // Keyboard status/response bytes that never start a key sequence
  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_BAT_ERR) || (b == PS2_ACK) ||
           (b == PS2_ECHO) || (b == PS2_RESEND) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  // One-hot position in {UP,DOWN,LEFT,RIGHT}; zero for non-arrow codes
  function automatic logic [3:0] arrow_mask(input logic [7:0] b);
    case (b)
      PS2_ARROW_UP:    return 4'b1000;
      PS2_ARROW_DOWN:  return 4'b0100;
      PS2_ARROW_LEFT:  return 4'b0010;
      PS2_ARROW_RIGHT: return 4'b0001;
      default:         return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_prefix_timeout.sv
// ps2_prefix_timeout: abandons a pending prefix that waits too long.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : clear the counter (byte accepted or decoder idle)
//   i_run          : count while a prefix is pending
//   o_expire       : counter has reached TIMEOUT_CYCLES-1 while running
module ps2_prefix_timeout #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int TIMEOUT_W      = 22
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expire
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] r_cnt;

  // Parks at LAST rather than wrapping; the decoder leaves the prefix state anyway
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_run && (r_cnt == LAST);

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns the PS/2 receiver's byte strobe into key events.
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_code_valid/i_code : received byte strobe and value
//   i_code_err          : byte had a framing/parity error
//   o_evt_valid         : one-cycle key event pulse; o_evt_code/ext/brk held
//   o_evt_pause         : one-cycle pulse on a complete Pause sequence
//   o_arrows_held       : {UP,DOWN,LEFT,RIGHT} currently pressed
//   o_err_cnt           : saturating count of errored bytes
// Optional macro PS2DEC_TYPEMATIC_FILTER_EN suppresses repeated makes of the
// most recently pressed key.
//
// state      | meaning
// -----------+---------------------------------------------
// ST_IDLE    | waiting for the first byte of a sequence
// ST_EXT     | E0 seen
// ST_BRK     | F0 seen
// ST_EXT_BRK | E0 F0 seen
// ST_PAUSE   | inside E1 ... Pause sequence, index r_pause_idx
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int TIMEOUT_W      = 22
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_code_valid,
  input  logic [7:0] i_code,
  input  logic       i_code_err,
  output logic       o_evt_valid,
  output logic [7:0] o_evt_code,
  output logic       o_evt_ext,
  output logic       o_evt_brk,
  output logic       o_evt_pause,
  output logic [3:0] o_arrows_held,
  output logic [7:0] o_err_cnt
);

  ps2_state_e r_state;
  logic [2:0] r_pause_idx;

  logic       w_accept;
  logic       w_err_byte;
  logic       w_byte_ext;
  logic       w_byte_brk;
  logic       w_fake_shift;
  logic       w_key_byte;
  logic       w_suppress;
  logic       w_emit;
  logic       w_expire;
  logic [3:0] w_arrow;

  assign w_accept     = i_code_valid && !i_code_err;
  assign w_err_byte   = i_code_valid && i_code_err;
  assign w_byte_ext   = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
  assign w_byte_brk   = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
  assign w_fake_shift = (i_code == PS2_FAKE_LSHIFT) || (i_code == PS2_FAKE_RSHIFT);
  assign w_arrow      = arrow_mask(i_code);

  // Does the current byte complete a key (make or break)?
  always_comb begin
    w_key_byte = 1'b0;
    case (r_state)
      ST_IDLE:    w_key_byte = (i_code != PS2_EXT) && (i_code != PS2_BRK) &&
                               (i_code != PS2_PAUSE) && !is_status(i_code);
      ST_EXT:     w_key_byte = (i_code != PS2_BRK) && !w_fake_shift;
      ST_BRK:     w_key_byte = 1'b1;
      ST_EXT_BRK: w_key_byte = !w_fake_shift;
      default:    w_key_byte = 1'b0;
    endcase
  end

`ifdef PS2DEC_TYPEMATIC_FILTER_EN
  logic       r_tm_vld;
  logic [8:0] r_tm_key;
  logic       w_tm_hit;

  assign w_tm_hit   = r_tm_vld && (r_tm_key == {w_byte_ext, i_code});
  assign w_suppress = w_tm_hit && !w_byte_brk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tm_vld <= 1'b0;
      r_tm_key <= '0;
    end else if (w_accept && w_key_byte) begin
      if (!w_byte_brk) begin
        r_tm_vld <= 1'b1;
        r_tm_key <= {w_byte_ext, i_code};
      end else if (w_tm_hit) begin
        r_tm_vld <= 1'b0;
      end
    end
  end
`else
  assign w_suppress = 1'b0;
`endif

  assign w_emit = w_accept && w_key_byte && !w_suppress;

  ps2_prefix_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    ((r_state == ST_IDLE) || i_code_valid),
    .i_run    (r_state != ST_IDLE),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_pause_idx   <= '0;
      o_evt_valid   <= 1'b0;
      o_evt_code    <= '0;
      o_evt_ext     <= 1'b0;
      o_evt_brk     <= 1'b0;
      o_evt_pause   <= 1'b0;
      o_arrows_held <= '0;
      o_err_cnt     <= '0;
    end else begin
      o_evt_valid <= w_emit;
      o_evt_pause <= 1'b0;

      if (w_emit) begin
        o_evt_code <= i_code;
        o_evt_ext  <= w_byte_ext;
        o_evt_brk  <= w_byte_brk;
        // Keypad codes share values with the arrows; only E0 versions count
        if (w_byte_ext) begin
          o_arrows_held <= w_byte_brk ? (o_arrows_held & ~w_arrow)
                                      : (o_arrows_held | w_arrow);
        end
      end

      if (w_err_byte) begin
        if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
        r_state     <= ST_IDLE;
        r_pause_idx <= '0;
      end else if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            if (i_code == PS2_EXT) begin
              r_state <= ST_EXT;
            end else if (i_code == PS2_BRK) begin
              r_state <= ST_BRK;
            end else if (i_code == PS2_PAUSE) begin
              r_state     <= ST_PAUSE;
              r_pause_idx <= 3'd1;
            end
          end
          ST_EXT: begin
            r_state <= (i_code == PS2_BRK) ? ST_EXT_BRK : ST_IDLE;
          end
          ST_PAUSE: begin
            // A mismatching byte is dropped, not re-parsed as a new sequence
            if ((i_code == PS2_PAUSE_SEQ[r_pause_idx]) && (r_pause_idx != 3'd7)) begin
              r_pause_idx <= r_pause_idx + 3'd1;
            end else begin
              o_evt_pause <= (i_code == PS2_PAUSE_SEQ[r_pause_idx]);
              r_state     <= ST_IDLE;
              r_pause_idx <= '0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end else if (w_expire) begin
        r_state     <= ST_IDLE;
        r_pause_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;

  localparam int TO = 100;
`ifdef PS2DEC_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_code_valid = 1'b0;
  logic [7:0] i_code = 8'h00;
  logic       i_code_err = 1'b0;
  logic       o_evt_valid;
  logic [7:0] o_evt_code;
  logic       o_evt_ext;
  logic       o_evt_brk;
  logic       o_evt_pause;
  logic [3:0] o_arrows_held;
  logic [7:0] o_err_cnt;

  always #5 i_clk = ~i_clk;

  ps2_scancode_decoder #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_W      (7)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_code_valid  (i_code_valid),
    .i_code        (i_code),
    .i_code_err    (i_code_err),
    .o_evt_valid   (o_evt_valid),
    .o_evt_code    (o_evt_code),
    .o_evt_ext     (o_evt_ext),
    .o_evt_brk     (o_evt_brk),
    .o_evt_pause   (o_evt_pause),
    .o_arrows_held (o_arrows_held),
    .o_err_cnt     (o_err_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_evt    = 0;
  int n_pause  = 0;
  logic [9:0] obs_q[$];

  // Event monitor, sampled mid-cycle
  always @(negedge i_clk) begin
    if (o_evt_valid) begin
      n_evt++;
      obs_q.push_back({o_evt_code, o_evt_ext, o_evt_brk});
    end
    if (o_evt_pause) n_pause++;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    chk({tag, ".valid"}, o_evt_valid, 1);
    chk({tag, ".evt"}, {o_evt_code, o_evt_ext, o_evt_brk}, {code, ext, brk});
  endtask

  // Called and returns at posedge+1; the byte is captured at the next posedge
  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    i_code_valid = 1'b1;
    i_code       = b;
    i_code_err   = err;
    @(posedge i_clk);
    #1;
    i_code_valid = 1'b0;
    i_code_err   = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge i_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    idle(2);
    i_rst_n = 1'b1;
    idle(1);
  endtask

  logic [7:0] pause_seq [8];
  logic [7:0] status_b [7];
  logic [7:0] arrow_b [4];
  logic [7:0] bq[$];
  logic [9:0] exp_q[$];
  int e0, p0;

  initial begin
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    status_b  = '{8'hAA, 8'hFC, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    arrow_b   = '{8'h75, 8'h72, 8'h6B, 8'h74};

    // Reset values
    idle(3);
    chk("rst.valid", o_evt_valid, 0);
    chk("rst.evt", {o_evt_code, o_evt_ext, o_evt_brk}, 0);
    chk("rst.pause", o_evt_pause, 0);
    chk("rst.arrows", o_arrows_held, 0);
    chk("rst.errcnt", o_err_cnt, 0);
    i_rst_n = 1'b1;
    idle(1);

    // Plain make then break
    send(8'h1C);
    chk_evt("mk1C", 8'h1C, 0, 0);
    idle(1);
    chk("mk1C.pulse", o_evt_valid, 0);
    chk("mk1C.held", o_evt_code, 8'h1C);
    send(8'hF0);
    chk("brkpfx.novalid", o_evt_valid, 0);
    send(8'h1C);
    chk_evt("brk1C", 8'h1C, 0, 1);
    idle(1);
    chk("two.events", n_evt, 2);

    // Arrow tracking
    send(8'hE0); send(8'h75);
    chk_evt("up.mk", 8'h75, 1, 0);
    chk("up.arrows", o_arrows_held, 4'b1000);
    send(8'hE0); send(8'h6B);
    chk_evt("left.mk", 8'h6B, 1, 0);
    chk("left.arrows", o_arrows_held, 4'b1010);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk_evt("up.brk", 8'h75, 1, 1);
    chk("upbrk.arrows", o_arrows_held, 4'b0010);
    send(8'h75);
    chk_evt("kp8.mk", 8'h75, 0, 0);
    chk("kp8.arrows", o_arrows_held, 4'b0010);

    // Fake shift and status bytes
    idle(1);
    e0 = n_evt;
    send(8'hAA); chk("aa.novalid", o_evt_valid, 0);
    send(8'hE0); send(8'h12); chk("fake.novalid", o_evt_valid, 0);
    send(8'hFA); chk("fa.novalid", o_evt_valid, 0);
    send(8'hE0); send(8'h7C);
    chk_evt("prtsc", 8'h7C, 1, 0);
    idle(1);
    chk("prtsc.count", n_evt - e0, 1);

    // Pause sequence
    e0 = n_evt; p0 = n_pause;
    foreach (pause_seq[i]) send(pause_seq[i]);
    chk("pause.pulse", o_evt_pause, 1);
    chk("pause.novalid", o_evt_valid, 0);
    idle(1);
    chk("pause.onecycle", o_evt_pause, 0);
    chk("pause.count", n_pause - p0, 1);
    chk("pause.noevt", n_evt - e0, 0);
    for (int i = 0; i < 4; i++) send(pause_seq[i]);
    send(8'h15);
    chk("pausebad.novalid", o_evt_valid, 0);
    send(8'h1C);
    chk_evt("pausebad.idle", 8'h1C, 0, 0);
    idle(1);
    chk("pausebad.count", n_pause - p0, 1);

    // Timeout boundary: byte on the expiry cycle wins, one cycle later it does not
    send(8'hE0); idle(TO - 1); send(8'h74);
    chk_evt("to.edge.win", 8'h74, 1, 0);
    chk("to.edge.arrows", o_arrows_held, 4'b0011);
    send(8'hE0); idle(TO); send(8'h74);
    chk_evt("to.expired", 8'h74, 0, 0);
    chk("to.expired.arrows", o_arrows_held, 4'b0011);
    send(8'hE0); idle(TO + 10); send(8'h1C);
    chk_evt("to.long", 8'h1C, 0, 0);

    // Errored bytes
    idle(1);
    send(8'hE0);
    e0 = n_evt;
    send(8'h55, 1'b1);
    chk("err.cnt1", o_err_cnt, 1);
    chk("err.novalid", o_evt_valid, 0);
    send(8'h1C);
    chk_evt("err.toidle", 8'h1C, 0, 0);
    idle(1);
    e0 = n_evt;
    for (int i = 0; i < 253; i++) send(8'($urandom), 1'b1);
    chk("err.254", o_err_cnt, 254);
    send(8'($urandom), 1'b1);
    chk("err.255", o_err_cnt, 255);
    for (int i = 0; i < 45; i++) send(8'($urandom), 1'b1);
    chk("err.sat", o_err_cnt, 255);
    idle(1);
    chk("err.noevt", n_evt - e0, 0);

    // Reset in mid sequence
    send(8'hE0);
    i_rst_n = 1'b0;
    #2;
    chk("midrst.arrows", o_arrows_held, 0);
    chk("midrst.errcnt", o_err_cnt, 0);
    chk("midrst.evt", {o_evt_code, o_evt_ext, o_evt_brk}, 0);
    idle(2);
    i_rst_n = 1'b1;
    idle(1);
    send(8'h1C);
    chk_evt("midrst.1C", 8'h1C, 0, 0);
    send(8'hF0); send(8'h1C);

    // Typematic repeats
    idle(1);
    e0 = n_evt;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    idle(1);
    chk("typematic.count", n_evt - e0, FILT ? 3 : 5);
    chk("typematic.last", obs_q[obs_q.size() - 1], {8'h1C, 1'b0, 1'b0});
    if (FILT) chk("typematic.brk", obs_q[obs_q.size() - 2], {8'h1C, 1'b0, 1'b1});

    // Randomized key stream against a key-level reference model
    do_reset();
    obs_q.delete();
    begin
      logic [3:0] exp_arrows = 4'b0000;
      logic       tm_vld = 1'b0;
      logic [8:0] tm_key = '0;
      int         exp_pause = 0;
      p0 = n_pause;
      for (int a = 0; a < 150; a++) begin
        int kind;
        kind = $urandom_range(0, 9);
        bq.delete();
        if (kind <= 6) begin
          logic [7:0] code;
          logic ext, brk, emit;
          if ($urandom_range(0, 1)) code = arrow_b[$urandom_range(0, 3)];
          else begin
            do code = 8'($urandom_range(1, 8'h83));
            while (code == 8'h12 || code == 8'h59);
          end
          ext = 1'($urandom_range(0, 1));
          brk = 1'($urandom_range(0, 1));
          if (ext) bq.push_back(8'hE0);
          if (brk) bq.push_back(8'hF0);
          bq.push_back(code);
          emit = 1'b1;
          if (!brk) begin
            if (FILT && tm_vld && tm_key == {ext, code}) emit = 1'b0;
            else begin tm_vld = 1'b1; tm_key = {ext, code}; end
          end else if (tm_vld && tm_key == {ext, code}) tm_vld = 1'b0;
          if (emit) begin
            exp_q.push_back({code, ext, brk});
            if (ext) for (int k = 0; k < 4; k++)
              if (arrow_b[k] == code) exp_arrows[3 - k] = !brk;
          end
        end else if (kind == 7) begin
          bq.push_back(status_b[$urandom_range(0, 6)]);
        end else if (kind == 8) begin
          foreach (pause_seq[i]) bq.push_back(pause_seq[i]);
          exp_pause++;
        end else begin
          bq.push_back(8'hE1); bq.push_back(8'h14); bq.push_back(8'h1C);
        end
        foreach (bq[i]) begin
          send(bq[i]);
          idle($urandom_range(0, 2));
        end
      end
      idle(3);
      chk("rnd.count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        chk($sformatf("rnd.evt%0d", i), obs_q[i], exp_q[i]);
      chk("rnd.pause", n_pause - p0, exp_pause);
      chk("rnd.arrows", o_arrows_held, exp_arrows);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Downstream consumer of the PS/2 receiver's 8-bit scan-code strobe.
- Parses Set-2 prefix sequences (E0 extended, F0 break, E1 Pause) and drops keyboard status bytes.
- Emits one single-cycle key event (code, extended flag, break flag).
- Keeps a held-state bitmap for the four arrow keys, for the game/display logic.

Parameters:
- TIMEOUT_CYCLES, 2500000, CLK cycles a pending prefix may wait for its next byte before being abandoned (25 ms at 100 MHz).
- TIMEOUT_W, 22, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  board clock; single clock domain.
- RST  in  1  asynchronous, active-low reset.
- CODE_VALID  in  1  one-cycle strobe: CODE holds a received byte.
- CODE  in  8  received scan-code byte.
- CODE_ERR  in  1  qualifies CODE_VALID: framing/parity error on this byte.
- EVT_VALID  out  1  one-cycle pulse: a key event is presented.
- EVT_CODE  out  8  final scan code of the event (prefix bytes stripped).
- EVT_EXT  out  1  event was E0-prefixed.
- EVT_BREAK  out  1  event is a key release.
- EVT_PAUSE  out  1  pulse: full 8-byte Pause sequence received.
- ARROWS_HELD  out  4  {UP,DOWN,LEFT,RIGHT} currently pressed.
- ERR_CNT  out  8  saturating count of CODE_ERR bytes.

Behaviour:
- Reset (RST=0, async):
  - All outputs 0; FSM in IDLE; timeout counter 0; Pause index 0.
  - Asserting reset mid-sequence discards the partial prefix with no event.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
- Transitions, applied only on CODE_VALID with CODE_ERR=0:
  - IDLE: E0→EXT; F0→BRK; E1→PAUSE (index=1); AA/FC/FA/EE/FE/00/FF dropped, stay IDLE; other→emit make (ext=0), stay IDLE.
  - EXT: F0→EXT_BRK; 12 or 59 (fake shift)→IDLE with no event; other→emit make (ext=1)→IDLE.
  - BRK: any byte→emit break (ext=0)→IDLE.
  - EXT_BRK: 12 or 59→IDLE with no event; other→emit break (ext=1)→IDLE.
  - PAUSE: compares against the expected sequence E1 14 77 E1 F0 14 F0 77.
    - Match increments the index; the 8th match pulses EVT_PAUSE→IDLE.
    - Mismatch→IDLE with no event; the mismatching byte is discarded, not re-parsed.
- Latency:
  - EVT_VALID asserts the cycle after the final byte's CODE_VALID.
  - EVT_CODE/EXT/BREAK are registered and held until the next event.
- CODE_VALID with CODE_ERR=1:
  - ERR_CNT += 1, saturating at 255.
  - FSM→IDLE; no event.
- Timeout:
  - Counter runs while the state is not IDLE; cleared on every accepted byte and in IDLE.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE with no event.
  - If a byte arrives in the same cycle, the byte wins.
- Arrow tracking:
  - Applies to extended events with code 75/72/6B/74 (UP/DOWN/LEFT/RIGHT).
  - Make sets the bit and break clears it, in the same cycle EVT_VALID rises.
  - Non-extended 75/72/6B/74 (keypad) do not affect ARROWS_HELD.
- CODE_VALID on consecutive cycles is legal; every byte is processed, and there is no backpressure.

Optional Feature:
- Macro: PS2DEC_TYPEMATIC_FILTER_EN.
- Defined:
  - A register holds the last make {ext,code} plus a valid bit.
  - A make identical to it is suppressed (no EVT_VALID).
  - A break of that key clears the valid bit.
  - A make of a different key replaces it.
  - Reset clears the register.
- Undefined: every typematic repeat make produces an event.

Decomposition:
- Package ps2_pkg holds:
  - Byte constants: PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT_OK=AA, PS2_BAT_ERR=FC, PS2_ACK=FA, PS2_ECHO=EE, PS2_RESEND=FE.
  - Arrow codes 75/72/6B/74.
  - FSM state enum.
  - The 8-entry Pause sequence array.
- Single sub-module ps2_prefix_timeout: the timeout counter with clear/run inputs and an expire output.

Test Plan:
- Bytes 1C, then F0 1C → make {code=1C,ext=0,brk=0}, then break {1C,0,1}; exactly two EVT_VALID pulses, each one cycle after the last byte.
- E0 75, E0 6B, E0 F0 75 → ARROWS_HELD 1000→1010→0010; events {75,1,0},{6B,1,0},{75,1,1}.
- E0 12 E0 7C (PrtSc make) → only event {7C,1,0}; AA and FA interleaved produce no events.
- E1 14 77 E1 F0 14 F0 77 → single EVT_PAUSE pulse, no EVT_VALID. Repeat with a mismatch at byte 5 → no pulse, FSM back in IDLE.
- E0 then silence for TIMEOUT_CYCLES (set to 100) → back to IDLE; a following 1C yields {1C,0,0}.
- 300 CODE_ERR bytes → ERR_CNT=255. With PS2DEC_TYPEMATIC_FILTER_EN: 1C 1C 1C F0 1C 1C → events make, break, make only.
